// File: rtl/sprite_compositor_if.sv
// Pixel stream bundle for the sprite compositor: the screen coordinate and
// per-layer palette indices going in, the composited pixel coming out.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12
);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic [9:0]              h_cnt;
    logic [9:0]              v_cnt;
    logic                    valid_in;
    logic [4*NUM_LAYERS-1:0] layer_idx;
    logic [COLOR_W-1:0]      pixel_out;
    logic                    valid_out;
    logic                    hit_any;
    logic [LW-1:0]           hit_layer;

    modport master (
        output h_cnt, v_cnt, valid_in, layer_idx,
        input  pixel_out, valid_out, hit_any, hit_layer
    );

    modport slave (
        input  h_cnt, v_cnt, valid_in, layer_idx,
        output pixel_out, valid_out, hit_any, hit_layer
    );
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage multi-layer sprite compositor.
//   Stage 1: wrap-around windowing against the active (frame-latched) geometry.
//   Stage 2: per-layer palette lookup and transparency (index 0) test.
//   Stage 3: fixed priority resolve, layer 0 highest, background fallback.
// Geometry is double-buffered: cfg_* only takes effect on frame_start.
module sprite_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int SCREEN_H   = 320,
    parameter int SCREEN_V   = 240,
    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    sprite_compositor_if.slave       px,
    input  logic                     frame_start,
    input  logic [10*NUM_LAYERS-1:0] cfg_pos_h,
    input  logic [10*NUM_LAYERS-1:0] cfg_pos_v,
    input  logic [10*NUM_LAYERS-1:0] cfg_size_h,
    input  logic [10*NUM_LAYERS-1:0] cfg_size_v,
    input  logic [NUM_LAYERS-1:0]    cfg_en,
    input  logic [COLOR_W-1:0]       bg_color,
    input  logic                     pal_we,
    input  logic [LW-1:0]            pal_layer,
    input  logic [3:0]               pal_addr,
    input  logic [COLOR_W-1:0]       pal_wdata
);
    localparam logic [9:0]  SCR_H10 = 10'(SCREEN_H);
    localparam logic [9:0]  SCR_V10 = 10'(SCREEN_V);
    localparam logic [10:0] SCR_H11 = 11'(SCREEN_H);
    localparam logic [10:0] SCR_V11 = 11'(SCREEN_V);

    // Active configuration
    logic [9:0]            pos_h_r  [NUM_LAYERS];
    logic [9:0]            pos_v_r  [NUM_LAYERS];
    logic [9:0]            size_h_r [NUM_LAYERS];
    logic [9:0]            size_v_r [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] en_r;

    // Palette storage
    logic [COLOR_W-1:0]    pal_r [NUM_LAYERS][16];

    // Stage 1
    logic [10:0]             sh_sum_s [NUM_LAYERS];
    logic [10:0]             sv_sum_s [NUM_LAYERS];
    logic [10:0]             sh_s     [NUM_LAYERS];
    logic [10:0]             sv_s     [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   in_win_s;
    logic                    s1_valid_r;
    logic [4*NUM_LAYERS-1:0] s1_idx_r;
    logic [NUM_LAYERS-1:0]   s1_win_r;

    // Stage 2
    logic [COLOR_W-1:0]      color_s     [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   opaque_s;
    logic                    s2_valid_r;
    logic [COLOR_W-1:0]      s2_color_r  [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]   s2_opaque_r;

    // Stage 3
    logic [COLOR_W-1:0]      win_pix_s;
    logic                    win_hit_s;
    logic [LW-1:0]           win_layer_s;
    logic [COLOR_W-1:0]      pixel_out_r;
    logic                    valid_out_r;
    logic                    hit_any_r;
    logic [LW-1:0]           hit_layer_r;

    // Latch next-frame geometry on frame_start; an off-screen offset pair is rejected
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                pos_h_r[k]  <= 10'd0;
                pos_v_r[k]  <= 10'd0;
                size_h_r[k] <= 10'd0;
                size_v_r[k] <= 10'd0;
            end
            en_r <= '0;
        end else if (frame_start) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if ((cfg_pos_h[10*k +: 10] < SCR_H10) && (cfg_pos_v[10*k +: 10] < SCR_V10)) begin
                    pos_h_r[k] <= cfg_pos_h[10*k +: 10];
                    pos_v_r[k] <= cfg_pos_v[10*k +: 10];
                end else begin
                    pos_h_r[k] <= pos_h_r[k];
                    pos_v_r[k] <= pos_v_r[k];
                end
                size_h_r[k] <= cfg_size_h[10*k +: 10];
                size_v_r[k] <= cfg_size_v[10*k +: 10];
            end
            en_r <= cfg_en;
        end else begin
            en_r <= en_r;
        end
    end

    // Palette write port; an out-of-range layer select is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                for (int a = 0; a < 16; a++) begin
                    pal_r[k][a] <= '0;
                end
            end
        end else if (pal_we && (32'(pal_layer) < NUM_LAYERS)) begin
            pal_r[pal_layer][pal_addr] <= pal_wdata;
        end else begin
            pal_r <= pal_r;
        end
    end

    // Stage 1 window test: scroll, wrap once at the screen edge, compare to size
    always_comb begin
        in_win_s = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            sh_sum_s[k] = {1'b0, px.h_cnt} + {1'b0, pos_h_r[k]};
            sv_sum_s[k] = {1'b0, px.v_cnt} + {1'b0, pos_v_r[k]};
            sh_s[k]     = (sh_sum_s[k] >= SCR_H11) ? (sh_sum_s[k] - SCR_H11) : sh_sum_s[k];
            sv_s[k]     = (sv_sum_s[k] >= SCR_V11) ? (sv_sum_s[k] - SCR_V11) : sv_sum_s[k];
            in_win_s[k] = en_r[k] & (sh_s[k] < {1'b0, size_h_r[k]})
                                  & (sv_s[k] < {1'b0, size_v_r[k]});
        end
    end

    // Stage 1 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_idx_r   <= '0;
            s1_win_r   <= '0;
        end else begin
            s1_valid_r <= px.valid_in;
            s1_idx_r   <= px.layer_idx;
            s1_win_r   <= in_win_s;
        end
    end

    // Stage 2 palette lookup; index 0 is the transparent key on every layer
    always_comb begin
        opaque_s = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            color_s[k]  = pal_r[k][s1_idx_r[4*k +: 4]];
            opaque_s[k] = s1_win_r[k] & (s1_idx_r[4*k +: 4] != 4'd0);
        end
    end

    // Stage 2 register
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            s2_opaque_r <= '0;
            for (int k = 0; k < NUM_LAYERS; k++) begin
                s2_color_r[k] <= '0;
            end
        end else begin
            s2_valid_r  <= s1_valid_r;
            s2_opaque_r <= opaque_s;
            s2_color_r  <= color_s;
        end
    end

    // Stage 3 priority resolve: scan high to low so the lowest opaque layer wins
    always_comb begin
        win_pix_s   = bg_color;
        win_hit_s   = 1'b0;
        win_layer_s = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            win_pix_s   = s2_opaque_r[k] ? s2_color_r[k] : win_pix_s;
            win_hit_s   = s2_opaque_r[k] | win_hit_s;
            win_layer_s = s2_opaque_r[k] ? LW'(k) : win_layer_s;
        end
    end

    // Stage 3 output register; blanked whenever the pixel is not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out_r <= '0;
            valid_out_r <= 1'b0;
            hit_any_r   <= 1'b0;
            hit_layer_r <= '0;
        end else if (s2_valid_r) begin
            pixel_out_r <= win_pix_s;
            valid_out_r <= 1'b1;
            hit_any_r   <= win_hit_s;
            hit_layer_r <= win_layer_s;
        end else begin
            pixel_out_r <= '0;
            valid_out_r <= 1'b0;
            hit_any_r   <= 1'b0;
            hit_layer_r <= '0;
        end
    end

    assign px.pixel_out = pixel_out_r;
    assign px.valid_out = valid_out_r;
    assign px.hit_any   = hit_any_r;
    assign px.hit_layer = hit_layer_r;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a streamed vector table for the
// windowing/priority function plus hand sequences for reset, double-buffered
// configuration and the palette write hazard.
module tb_sprite_compositor;
    localparam int NL = 4;
    localparam int CW = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           frame_start;
    logic [10*NL-1:0] cfg_pos_h, cfg_pos_v, cfg_size_h, cfg_size_v;
    logic [NL-1:0]  cfg_en;
    logic [CW-1:0]  bg_color;
    logic           pal_we;
    logic [1:0]     pal_layer;
    logic [3:0]     pal_addr;
    logic [CW-1:0]  pal_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) px ();

    sprite_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .SCREEN_H(320), .SCREEN_V(240)) dut (
        .clk(clk), .rst(rst), .px(px), .frame_start(frame_start),
        .cfg_pos_h(cfg_pos_h), .cfg_pos_v(cfg_pos_v),
        .cfg_size_h(cfg_size_h), .cfg_size_v(cfg_size_v), .cfg_en(cfg_en),
        .bg_color(bg_color), .pal_we(pal_we), .pal_layer(pal_layer),
        .pal_addr(pal_addr), .pal_wdata(pal_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [15:0] idx;
        logic [11:0] pix;
        logic        ha;
        logic [1:0]  hl;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare {valid_out, hit_any, hit_layer, pixel_out} against expectations
    task automatic chk_out(input string name, input logic ev, input logic eha,
                           input logic [1:0] ehl, input logic [11:0] epix);
        logic [15:0] act;
        logic [15:0] exp;
        act = {px.valid_out, px.hit_any, px.hit_layer, px.pixel_out};
        exp = {ev, eha, ehl, epix};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got valid=%b hit=%b layer=%0d pix=%h, expected valid=%b hit=%b layer=%0d pix=%h",
                     name, act[15], act[14], act[13:12], act[11:0], ev, eha, ehl, epix);
        end
    endtask

    task automatic drive(input logic v, input logic [9:0] h, input logic [9:0] vc, input logic [15:0] idx);
        px.valid_in  = v;
        px.h_cnt     = h;
        px.v_cnt     = vc;
        px.layer_idx = idx;
    endtask

    // One isolated pixel, then check it 3 cycles later
    task automatic run_one(input string name, input logic [9:0] h, input logic [9:0] vc,
                           input logic [15:0] idx, input logic eha, input logic [1:0] ehl,
                           input logic [11:0] epix);
        drive(1'b1, h, vc, idx);
        tick();
        drive(1'b0, 10'd0, 10'd0, 16'h0000);
        tick();
        tick();
        chk_out(name, 1'b1, eha, ehl, epix);
    endtask

    task automatic pal_write(input logic [1:0] l, input logic [3:0] a, input logic [11:0] d);
        pal_we    = 1'b1;
        pal_layer = l;
        pal_addr  = a;
        pal_wdata = d;
        tick();
        pal_we    = 1'b0;
    endtask

    task automatic set_cfg(input int k, input logic [9:0] ph, input logic [9:0] pv,
                           input logic [9:0] sh, input logic [9:0] sv, input logic en);
        cfg_pos_h[10*k +: 10]  = ph;
        cfg_pos_v[10*k +: 10]  = pv;
        cfg_size_h[10*k +: 10] = sh;
        cfg_size_v[10*k +: 10] = sv;
        cfg_en[k]              = en;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        // Layer 0 (0,0) 16x16; layer 1 (0,0) 32x32; layer 2 (310,0) 20x240; layer 3 size_h=0
        vecs[0]  = '{1'b1, 10'd3,   10'd3,   16'h0005, 12'hF00, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 10'd16,  10'd3,   16'h0005, 12'h123, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 10'd3,   10'd3,   16'h0030, 12'h0F0, 1'b1, 2'd1};
        vecs[3]  = '{1'b1, 10'd3,   10'd3,   16'h0032, 12'hA0A, 1'b1, 2'd0};
        vecs[4]  = '{1'b1, 10'd5,   10'd100, 16'h0100, 12'h123, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 10'd15,  10'd100, 16'h0100, 12'h555, 1'b1, 2'd2};
        vecs[6]  = '{1'b1, 10'd15,  10'd100, 16'h0130, 12'h555, 1'b1, 2'd2};
        vecs[7]  = '{1'b1, 10'd3,   10'd3,   16'h7000, 12'h123, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 10'd319, 10'd239, 16'h0105, 12'h123, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 10'd10,  10'd3,   16'h0135, 12'hF00, 1'b1, 2'd0};
        vecs[10] = '{1'b1, 10'd20,  10'd20,  16'h0130, 12'h0F0, 1'b1, 2'd1};
        vecs[11] = '{1'b1, 10'd10,  10'd0,   16'h7100, 12'h555, 1'b1, 2'd2};
        vecs[12] = '{1'b0, 10'd3,   10'd3,   16'h0005, 12'h000, 1'b0, 2'd0};

        rst = 1'b1;
        frame_start = 1'b0;
        cfg_pos_h = '0; cfg_pos_v = '0; cfg_size_h = '0; cfg_size_v = '0; cfg_en = '0;
        bg_color = 12'h123;
        pal_we = 1'b0; pal_layer = 2'd0; pal_addr = 4'd0; pal_wdata = 12'h000;
        drive(1'b1, 10'd3, 10'd3, 16'h0005);

        // Reset held 2 cycles with valid_in high
        tick();
        chk_out("reset_c0", 1'b0, 1'b0, 2'd0, 12'h000);
        tick();
        chk_out("reset_c1", 1'b0, 1'b0, 2'd0, 12'h000);
        rst = 1'b0;
        tick();
        chk_out("flush_1", 1'b0, 1'b0, 2'd0, 12'h000);
        tick();
        chk_out("flush_2", 1'b0, 1'b0, 2'd0, 12'h000);
        tick();
        chk_out("first_bg", 1'b1, 1'b0, 2'd0, 12'h123);
        drive(1'b0, 10'd0, 10'd0, 16'h0000);

        // Palettes and geometry
        pal_write(2'd0, 4'd5, 12'hF00);
        pal_write(2'd0, 4'd2, 12'hA0A);
        pal_write(2'd1, 4'd3, 12'h0F0);
        pal_write(2'd2, 4'd1, 12'h555);
        pal_write(2'd3, 4'd7, 12'h777);
        set_cfg(0, 10'd0,   10'd0, 10'd16, 10'd16,  1'b1);
        set_cfg(1, 10'd0,   10'd0, 10'd32, 10'd32,  1'b1);
        set_cfg(2, 10'd310, 10'd0, 10'd20, 10'd240, 1'b1);
        set_cfg(3, 10'd0,   10'd0, 10'd0,  10'd100, 1'b1);
        pulse_frame();

        // Streamed table, one pixel per cycle; output i appears after tick i+2
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                drive(vecs[i].valid, vecs[i].h, vecs[i].v, vecs[i].idx);
            end else begin
                drive(1'b0, 10'd0, 10'd0, 16'h0000);
            end
            tick();
            if (i >= 2) begin
                chk_out($sformatf("vec%0d", i - 2), vecs[i-2].valid, vecs[i-2].ha,
                        vecs[i-2].hl, vecs[i-2].pix);
            end
        end

        // Off-screen offset rejected, size still updates (pos_h stays 310, size_h 40)
        set_cfg(2, 10'd320, 10'd0, 10'd40, 10'd240, 1'b1);
        pulse_frame();
        run_one("pos_keep", 10'd5,  10'd100, 16'h0100, 1'b0, 2'd0, 12'h123);
        run_one("size_upd", 10'd35, 10'd100, 16'h0100, 1'b1, 2'd2, 12'h555);

        // Shadow config change without frame_start has no effect
        set_cfg(0, 10'd5, 10'd0, 10'd16, 10'd16, 1'b1);
        run_one("shadow_hold", 10'd12, 10'd3, 16'h0005, 1'b1, 2'd0, 12'hF00);

        // frame_start coincident with pixel P: P old offset, P+1 new offset
        frame_start = 1'b1;
        drive(1'b1, 10'd12, 10'd3, 16'h0005);
        tick();
        frame_start = 1'b0;
        tick();
        drive(1'b0, 10'd0, 10'd0, 16'h0000);
        tick();
        chk_out("fs_old_P", 1'b1, 1'b1, 2'd0, 12'hF00);
        tick();
        chk_out("fs_new_P1", 1'b1, 1'b0, 2'd0, 12'h123);

        // Palette write as P reaches stage 2: P old colour, P+1 new colour
        drive(1'b1, 10'd3, 10'd3, 16'h0005);
        tick();
        pal_we = 1'b1; pal_layer = 2'd0; pal_addr = 4'd5; pal_wdata = 12'h00F;
        tick();
        pal_we = 1'b0;
        drive(1'b0, 10'd0, 10'd0, 16'h0000);
        tick();
        chk_out("pal_old_P", 1'b1, 1'b1, 2'd0, 12'hF00);
        tick();
        chk_out("pal_new_P1", 1'b1, 1'b1, 2'd0, 12'h00F);

        // Mid-frame reset together with frame_start: pipeline flushed, config cleared
        drive(1'b1, 10'd3, 10'd3, 16'h0005);
        tick();
        tick();
        tick();
        chk_out("pre_rst", 1'b1, 1'b1, 2'd0, 12'h00F);
        rst = 1'b1;
        frame_start = 1'b1;
        tick();
        chk_out("mid_rst", 1'b0, 1'b0, 2'd0, 12'h000);
        rst = 1'b0;
        frame_start = 1'b0;
        tick();
        chk_out("mid_flush_1", 1'b0, 1'b0, 2'd0, 12'h000);
        tick();
        chk_out("mid_flush_2", 1'b0, 1'b0, 2'd0, 12'h000);
        tick();
        chk_out("cfg_cleared", 1'b1, 1'b0, 2'd0, 12'h123);
        drive(1'b0, 10'd0, 10'd0, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised, pipelined multi-layer sprite compositor between the per-layer sprite ROMs and the VGA output register. Each cycle it takes the current screen coordinate and one 4-bit palette index per layer. It then applies per-layer wrap-around windowing and per-layer palette lookup, and resolves the layer priority. The result is one 12-bit pixel, 3 cycles later. Layer geometry is double-buffered and updates only at frame start, so sprites never tear mid-frame.

## Interface
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority
- COLOR_W, 12, RGB444 pixel width
- SCREEN_H, 320, horizontal wrap modulus
- SCREEN_V, 240, vertical wrap modulus
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- h_cnt, v_cnt  in  10 each  screen coordinate of the incoming pixel; must be < SCREEN_H / SCREEN_V when valid_in=1
- valid_in  in  1  coordinate and indices are valid (active video)
- layer_idx  in  4*NUM_LAYERS  per-layer palette index for this pixel; layer k at bits [4k+3:4k]
- frame_start  in  1  one-cycle pulse; latches the shadow configuration
- cfg_pos_h, cfg_pos_v  in  10*NUM_LAYERS  next-frame scroll offsets
- cfg_size_h, cfg_size_v  in  10*NUM_LAYERS  next-frame window sizes
- cfg_en  in  NUM_LAYERS  next-frame layer enables
- bg_color  in  COLOR_W  colour output when no layer hits; sampled in stage 3
- pal_we  in  1  palette write strobe
- pal_layer  in  $clog2(NUM_LAYERS) (min 1)  palette layer select
- pal_addr  in  4  palette entry
- pal_wdata  in  COLOR_W  palette entry data
- pixel_out  out  COLOR_W  composited pixel; 0 when valid_out=0
- valid_out  out  1  valid_in delayed 3 cycles
- hit_any  out  1  some layer supplied pixel_out
- hit_layer  out  $clog2(NUM_LAYERS) (min 1)  winning layer; 0 when hit_any=0

## Operation
- Active configuration (pos/size/en per layer) is held in registers. On frame_start=1, each layer's cfg_* is copied into them.
  - Exception: if a layer's cfg_pos_h >= SCREEN_H or cfg_pos_v >= SCREEN_V, that layer's pos_h/pos_v pair keeps its previous value. Its size and en still update.
- Stage 1 (registered), per layer k:
  - sh = h_cnt + pos_h[k] computed at 11 bits; subtract SCREEN_H once if sh >= SCREEN_H.
  - sv is computed the same way with v_cnt, pos_v[k] and SCREEN_V.
  - in_win[k] = en[k] & (sh < size_h[k]) & (sv < size_v[k]).
  - layer_idx, valid_in and in_win are registered.
- Stage 2 (registered): color[k] = palette[k][idx[k]]. opaque[k] = in_win[k] & (idx[k] != 0). Index 0 is the transparent key for every layer.
- Stage 3 (registered):
  - The lowest k with opaque[k] wins: pixel_out = color[k], hit_any=1, hit_layer=k.
  - With no winner: pixel_out = bg_color, hit_any=0, hit_layer=0.
  - If the stage-3 valid is 0: pixel_out=0, hit_any=0, hit_layer=0.
- Palette: NUM_LAYERS x 16 x COLOR_W registers, written on pal_we at [pal_layer][pal_addr]. A pal_layer >= NUM_LAYERS is ignored.
- size_h=0 or size_v=0 disables the layer (never in window). size >= SCREEN covers the full screen.

## Timing
- Reset (rst=1 at a clk edge), outputs: pixel_out=0, valid_out=0, hit_any=0, hit_layer=0.
- Reset, internal state: all pipeline valids 0, all active config 0 (all layers disabled), all palette entries 0.
- Reset mid-frame flushes the pipeline: valid_out is 0 for the 3 cycles after rst deasserts, regardless of valid_in.
- Latency is exactly 3 cycles, with throughput of one pixel per cycle. No stalls and no back-pressure.
- frame_start and valid_in in the same cycle: that pixel uses the OLD configuration. Pixels from the next cycle onward use the new one.
- Palette write at edge N affects stage-2 lookups at edge N+1 onward. A same-edge read of the written entry returns the old value.
- frame_start together with rst: rst wins and the config clears.

## Test plan
- Reset: hold rst 2 cycles, drive valid_in=1 throughout -> pixel_out=0 and valid_out=0 while rst=1 and for 3 cycles after; bg_color appears only once the first post-reset valid pixel emerges.
- Single layer: layer 0 configured pos=(0,0), size=(16,16), en=1 via frame_start; palette[0][5]=12'hF00; idx0=5 at (3,3) -> 3 cycles later pixel_out=12'hF00, hit_layer=0. Same idx at (16,3) -> bg_color, hit_any=0.
- Wrap-around: pos_h=310, size_h=20, h_cnt=5 -> sh=315 >= 20 -> miss. h_cnt=15 -> sh=5 -> hit. Also latch cfg_pos_h=320 -> pos_h stays 310.
- Priority and transparency, with layers 0 and 1 both in window:
  - idx0=0, idx1=3 (palette[1][3]=12'h0F0) -> 12'h0F0, hit_layer=1.
  - idx0=2 -> layer 0 colour, hit_layer=0.
- Frame double-buffer: change cfg_pos_h without frame_start -> output unchanged. Pulse frame_start in the same cycle as pixel P -> P uses the old offset and P+1 the new one.
- Palette hazard: write palette[0][5]=12'h00F in the cycle pixel P's index reaches stage 2 -> P shows the old colour and P+1 shows 12'h00F.
